// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - Round-robin burst arbiter sharing one fifo write port
//
// Purpose: grants one of N_REQ valid/ready producers at a time for a burst of
// up to MAX_BURST beats and forwards its beats through a one-entry registered
// output stage toward a fifo write port.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester valid
//   req_last_i   per-requester end-of-burst marker (qualified by valid)
//   req_data_i   per-requester data, requester k at [k*DATA_W +: DATA_W]
//   req_ready_o  per-requester ready (at most one bit set)
//   valid_o      beat valid toward the fifo
//   data_o       beat data toward the fifo
//   src_o        index of the requester that produced data_o
//   ready_i      fifo ready
//   grant_o      one-hot current grant, zero when no grant is held
//   busy_o       high while a grant is held
module fifo_rr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ-1:0]          req_last_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      valid_o,
    output logic [DATA_W-1:0]         data_o,
    output logic [IDX_W-1:0]          src_o,
    input  logic                      ready_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      busy_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    logic [0:0]        state_q,    state_d;
    logic [IDX_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]  gnt_idx_q,  gnt_idx_d;
    logic [N_REQ-1:0]  grant_q,    grant_d;
    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic [IDX_W-1:0]  src_q,      src_d;

    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand;
    logic              g_ready;
    logic              g_valid;
    logic              xfer;
    logic              burst_end;

    // Circular scan starting at rr_ptr; N_REQ is a power of two so the
    // index addition wraps naturally in IDX_W bits.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            cand = rr_ptr_q + IDX_W'(i);
            if (!sel_found && req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // The granted requester may push whenever the output stage is empty or
    // draining this cycle; a held beat under backpressure blocks everyone.
    assign g_ready = (state_q == ST_BURST) && (!valid_q || ready_i);
    assign g_valid = req_valid_i[gnt_idx_q];
    assign xfer    = g_ready && g_valid;

    // Idle release ends the burst without a transfer; otherwise it ends on
    // the transferring beat carrying last or hitting the beat cap.
    assign burst_end = (state_q == ST_BURST) &&
                       (!g_valid ||
                        (xfer && (req_last_i[gnt_idx_q] || beat_cnt_q == LAST_BEAT)));

    always_comb begin
        req_ready_o = '0;
        if (g_ready) begin
            req_ready_o[gnt_idx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        gnt_idx_d  = gnt_idx_q;
        grant_d    = grant_q;
        valid_d    = valid_q;
        data_d     = data_q;
        src_d      = src_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d    = ST_BURST;
                    gnt_idx_d  = sel_idx;
                    grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (burst_end) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = gnt_idx_q + IDX_W'(1);
                end
            end
        endcase

        // A load takes priority over a drain so back-to-back beats flow
        // without a bubble.
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = req_data_i[gnt_idx_q*DATA_W +: DATA_W];
            src_d   = gnt_idx_q;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            gnt_idx_q  <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            src_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_idx_q  <= gnt_idx_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            src_q      <= src_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign src_o   = src_q;
    assign grant_o = grant_q;
    assign busy_o  = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - Directed table-driven bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        valid_o;
    logic [7:0]  data_o;
    logic [1:0]  src_o;
    logic        ready;
    logic [3:0]  grant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fifo_rr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .src_o       (src_o),
        .ready_i     (ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {valid, data, src, grant, req_ready, busy}
    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] lst,
                                input logic [31:0] dat, input logic rdy,
                                input logic ev, input logic [7:0] ed, input logic [1:0] es,
                                input logic [3:0] eg, input logic [3:0] er, input logic eb);
        vec_t v;
        v.vld = vld; v.lst = lst; v.dat = dat; v.rdy = rdy;
        v.exp = {ev, ed, es, eg, er, eb};
        return v;
    endfunction

    function automatic logic [19:0] observe();
        return {valid_o, data_o, src_o, grant, req_ready, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        logic [7:0] got[$];
        int idx;
        int stalls;
        int cyc;

        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", 32'(observe()), 32'h0);
        rst = 1'b0;

        // single requester, 3 beats, last on the third
        vecs.push_back(mk(4'b0100, 4'b0000, 32'h00A10000, 1, 0, 8'h00, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b0100, 4'b0000, 32'h00A10000, 1, 0, 8'h00, 0, 4'b0100, 4'b0100, 1));
        vecs.push_back(mk(4'b0100, 4'b0000, 32'h00A20000, 1, 1, 8'hA1, 2, 4'b0100, 4'b0100, 1));
        vecs.push_back(mk(4'b0100, 4'b0100, 32'h00A30000, 1, 1, 8'hA2, 2, 4'b0100, 4'b0100, 1));
        vecs.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 1, 1, 8'hA3, 2, 4'b0000, 4'b0000, 0));
        // all requesters, last on every beat; first grant proves rr_ptr == 3
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'hA3, 2, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'hA3, 2, 4'b1000, 4'b1000, 1));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h13, 3, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h13, 3, 4'b0001, 4'b0001, 1));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h10, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h10, 0, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h11, 1, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h11, 1, 4'b0100, 4'b0100, 1));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h12, 2, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h12, 2, 4'b1000, 4'b1000, 1));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h13, 3, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h13, 3, 4'b0001, 4'b0001, 1));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 1, 8'h10, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 32'h13121110, 1, 0, 8'h10, 0, 4'b0010, 4'b0010, 1));
        // requester 1 streams 10 beats without last: bursts of 4, 4, 2
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B000, 1, 1, 8'h11, 1, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B000, 1, 0, 8'h11, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B100, 1, 1, 8'hB0, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B200, 1, 1, 8'hB1, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B300, 1, 1, 8'hB2, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B400, 1, 1, 8'hB3, 1, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B400, 1, 0, 8'hB3, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B500, 1, 1, 8'hB4, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B600, 1, 1, 8'hB5, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B700, 1, 1, 8'hB6, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B800, 1, 1, 8'hB7, 1, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B800, 1, 0, 8'hB7, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000B900, 1, 1, 8'hB8, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 1, 1, 8'hB9, 1, 4'b0010, 4'b0010, 1));
        vecs.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'hB9, 1, 4'b0000, 4'b0000, 0));
        // idle release of requester 3 while requester 0 waits; rr wraps to 0
        vecs.push_back(mk(4'b1000, 4'b0000, 32'hC00000D0, 1, 0, 8'hB9, 1, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b1001, 4'b0000, 32'hC00000D0, 1, 0, 8'hB9, 1, 4'b1000, 4'b1000, 1));
        vecs.push_back(mk(4'b0001, 4'b0000, 32'hC00000D0, 1, 1, 8'hC0, 3, 4'b1000, 4'b1000, 1));
        vecs.push_back(mk(4'b0001, 4'b0000, 32'hC00000D0, 1, 0, 8'hC0, 3, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b0001, 4'b0001, 32'hC00000D0, 1, 0, 8'hC0, 3, 4'b0001, 4'b0001, 1));
        vecs.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 1, 1, 8'hD0, 0, 4'b0000, 4'b0000, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'hD0, 0, 4'b0000, 4'b0000, 0));

        foreach (vecs[i]) begin
            req_valid = vecs[i].vld;
            req_last  = vecs[i].lst;
            req_data  = vecs[i].dat;
            ready     = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d", i), 32'(observe()), 32'(vecs[i].exp));
            @(negedge clk);
        end

        // backpressure: requester 2 sends E0..E3, fifo stalls for 3 cycles
        idx = 0; stalls = 0; cyc = 0;
        while (got.size() < 4 && cyc < 40) begin
            ready     = !(cyc >= 4 && cyc < 7);
            req_valid = (idx < 4) ? 4'b0100 : 4'b0000;
            req_last  = (idx == 3) ? 4'b0100 : 4'b0000;
            req_data  = {8'h00, 8'hE0 + 8'(idx), 16'h0000};
            #1;
            if (valid_o && ready) begin
                got.push_back(data_o);
                chk("bp_src", 32'(src_o), 32'd2);
            end
            if (valid_o && !ready) begin
                stalls++;
                chk("bp_hold_data", 32'(data_o), 32'hE2);
                chk("bp_hold_ready", 32'(req_ready), 32'h0);
            end
            if (req_ready[2] && req_valid[2]) idx++;
            @(negedge clk);
            cyc++;
        end
        chk("bp_beats", 32'(got.size()), 32'd4);
        chk("bp_stalls", 32'(stalls), 32'd3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_beat%0d", i),
                (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'hE0 + 32'(i));
        end

        // reset while a beat is held under backpressure
        ready = 1'b1; req_last = '0; req_valid = 4'b0010; req_data = 32'h0000F000;
        #1;
        chk("rst_pre_idle_grant", 32'(grant), 32'h0);
        @(negedge clk);
        #1;
        chk("rst_pre_grant", 32'(grant), 32'b0010);
        @(negedge clk);
        ready = 1'b0; req_data = 32'h0000F100;
        #1;
        chk("rst_held_valid", 32'({valid_o, data_o}), 32'h1F0);
        chk("rst_held_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_clear", 32'({valid_o, grant, busy, req_ready}), 32'h0);
        rst = 1'b0; ready = 1'b1; req_valid = 4'b1111; req_data = 32'h13121110;
        @(negedge clk);
        #1;
        chk("rst_rr_restart", 32'(grant), 32'b0001);

        req_valid = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
